// File: rtl/gpio_ctrl_pkg.sv
// Shared types and constants for the GPIO write arbiter.
package gpio_ctrl_pkg;

    localparam int GPIO_W_DEF = 32;

    // Transaction FSM: sample requests, present grant, commit the write.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WRITE = 2'd2
    } gpio_arb_state_e;

    // Index of one of the two requesters.
    typedef logic req_idx_t;

endpackage

// File: rtl/gpio_rr_arbiter.sv
// Two-way round-robin pick with a registered last-winner pointer.
// The pick is combinational; the pointer only moves when the caller
// accepts the pick (i_update high while some request is present).
module gpio_rr_arbiter
    import gpio_ctrl_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_req,
    input  logic       i_update,
    output logic       o_any,
    output req_idx_t   o_winner,
    output logic [1:0] o_onehot
);

    req_idx_t r_last;
    req_idx_t w_winner;

    // Contended: the requester that did not win last time; otherwise the lone requester.
    always_comb begin
        w_winner = 1'b0;
        if (i_req == 2'b11) begin
            w_winner = ~r_last;
        end else if (i_req[1]) begin
            w_winner = 1'b1;
        end
    end

    // Pointer resets to requester 1 so requester 0 wins the first contended pick.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last <= 1'b1;
        end else if (i_update && o_any) begin
            r_last <= w_winner;
        end
    end

    assign o_any    = |i_req;
    assign o_winner = w_winner;
    assign o_onehot = o_any ? (w_winner ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: rtl/gpio_arbiter.sv
// Arbitrates two masked-write requesters onto one registered GPIO word.
// Handshake: o_gnt is a one-cycle acknowledge; a request bit is sampled only
// in IDLE, its data/mask only at that same edge, and the write lands one edge
// after the grant. A request still high on return to IDLE is a new request.
module gpio_arbiter
    import gpio_ctrl_pkg::*;
#(
    parameter int                GPIO_W    = GPIO_W_DEF,
    parameter logic [GPIO_W-1:0] RESET_VAL = '0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [1:0]        i_req,
    input  logic [GPIO_W-1:0] i_wdata0,
    input  logic [GPIO_W-1:0] i_wmask0,
    input  logic [GPIO_W-1:0] i_wdata1,
    input  logic [GPIO_W-1:0] i_wmask1,
    output logic [1:0]        o_gnt,
    output logic              o_busy,
    output logic [GPIO_W-1:0] o_gpio,
    output logic              o_changed,
    output gpio_arb_state_e   o_state
);

    gpio_arb_state_e   r_state;
    gpio_arb_state_e   w_state_next;
    logic [1:0]        r_gnt;
    logic [GPIO_W-1:0] r_data;
    logic [GPIO_W-1:0] r_mask;
    logic [GPIO_W-1:0] r_gpio;
    logic [GPIO_W-1:0] w_gpio_next;
    logic              r_changed;
    logic              w_any;
    req_idx_t          w_winner;
    logic [1:0]        w_onehot;
    logic              w_accept;

    assign w_accept = (r_state == IDLE) && w_any;

    gpio_rr_arbiter u_rr (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_req    (i_req),
        .i_update (r_state == IDLE),
        .o_any    (w_any),
        .o_winner (w_winner),
        .o_onehot (w_onehot)
    );

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: leave IDLE on any request, then step through unconditionally.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_any) w_state_next = GRANT;
            GRANT:   w_state_next = WRITE;
            WRITE:   w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Masked merge of the captured write into the current GPIO value.
    always_comb begin
        w_gpio_next = (r_gpio & ~r_mask) | (r_data & r_mask);
    end

    // Capture the winner's data/mask and raise its grant for the GRANT cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data <= '0;
            r_mask <= '0;
            r_gnt  <= 2'b00;
        end else begin
            r_gnt <= w_accept ? w_onehot : 2'b00;
            if (w_accept) begin
                r_data <= w_winner ? i_wdata1 : i_wdata0;
                r_mask <= w_winner ? i_wmask1 : i_wmask0;
            end
        end
    end

    // Commit the write on the GRANT -> WRITE edge and flag a real change.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_gpio    <= RESET_VAL;
            r_changed <= 1'b0;
        end else begin
            r_changed <= (r_state == GRANT) && (w_gpio_next != r_gpio);
            if (r_state == GRANT) begin
                r_gpio <= w_gpio_next;
            end
        end
    end

    assign o_gnt     = r_gnt;
    assign o_busy    = (r_state != IDLE);
    assign o_gpio    = r_gpio;
    assign o_changed = r_changed;
    assign o_state   = r_state;

endmodule

// File: tb/tb_gpio_arbiter.sv
// Directed bench for gpio_arbiter: stimulus pushes {gnt, changed, gpio}
// expectations; a monitor pops one per observed grant and checks the
// grant cycle, the write cycle and the return to IDLE.
module tb_gpio_arbiter;
  import gpio_ctrl_pkg::*;

  localparam int W  = 32;
  localparam int EW = W + 3;

  logic         clk;
  logic         rst_n;
  logic [1:0]   req;
  logic [W-1:0] wdata0, wmask0, wdata1, wmask1;
  logic [1:0]   gnt;
  logic         busy;
  logic [W-1:0] gpio;
  logic         changed;
  gpio_arb_state_e state;

  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  gpio_arbiter #(.GPIO_W(W), .RESET_VAL(32'h0000_0000)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_req     (req),
    .i_wdata0  (wdata0),
    .i_wmask0  (wmask0),
    .i_wdata1  (wdata1),
    .i_wmask1  (wmask1),
    .o_gnt     (gnt),
    .o_busy    (busy),
    .o_gpio    (gpio),
    .o_changed (changed),
    .o_state   (state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish (checks %0d)", checks);
    $fatal(1, "timeout");
  end

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push(input logic [1:0] g, input logic ch, input logic [W-1:0] v);
    exp_q.push_back({g, ch, v});
  endtask

  // Called at posedge+1 in IDLE; returns at posedge+1 with the FSM back in IDLE.
  task automatic issue(input logic [1:0] r, input logic [W-1:0] d0, input logic [W-1:0] m0,
                       input logic [W-1:0] d1, input logic [W-1:0] m1);
    wdata0 = d0; wmask0 = m0; wdata1 = d1; wmask1 = m1;
    req = r;
    @(posedge clk); #1;
    req = 2'b00;
    wdata0 = $urandom; wmask0 = $urandom; wdata1 = $urandom; wmask1 = $urandom;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && gnt != 2'b00) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_gnt: got %b expected none at %0t", gnt, $time);
        end else begin
          e = exp_q.pop_front();
          check("gnt", W'(gnt), W'(e[EW-1 -: 2]));
          check("busy_grant", W'(busy), W'(1));
          check("changed_grant", W'(changed), W'(0));
          @(negedge clk);
          check("gpio_write", gpio, e[W-1:0]);
          check("changed_write", W'(changed), W'(e[W]));
          check("gnt_write", W'(gnt), W'(0));
          check("busy_write", W'(busy), W'(1));
          @(negedge clk);
          check("busy_idle", W'(busy), W'(0));
          check("changed_idle", W'(changed), W'(0));
        end
      end
    end
  end

  // ---------------- invariant checker ----------------
  initial begin
    logic [W-1:0] prev_gpio;
    gpio_arb_state_e prev_state;
    prev_gpio  = '0;
    prev_state = IDLE;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        checks++;
        if ((gnt & (gnt - 2'b01)) != 2'b00 || (gnt != 2'b00 && !busy)) begin
          errors++;
          $display("FAIL inv_gnt: gnt %b busy %b at %0t", gnt, busy, $time);
        end
        if (changed && !(state == WRITE && prev_state == GRANT)) begin
          errors++;
          $display("FAIL inv_changed: state %0d prev %0d at %0t", state, prev_state, $time);
        end
        if (gpio !== prev_gpio && !(state == WRITE && prev_state == GRANT)) begin
          errors++;
          $display("FAIL inv_gpio: got %h was %h state %0d at %0t", gpio, prev_gpio, state, $time);
        end
      end
      prev_gpio  = gpio;
      prev_state = state;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    req = 2'b00;
    wdata0 = '0; wmask0 = '0; wdata1 = '0; wmask1 = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_gpio", gpio, 32'h0);
    check("reset_gnt", W'(gnt), W'(0));
    check("reset_busy", W'(busy), W'(0));
    check("reset_changed", W'(changed), W'(0));
    check("reset_state", W'(state), W'(IDLE));
    #6 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single request from requester 0 out of reset.
    push(2'b01, 1'b1, 32'h0000_00FF);
    issue(2'b01, 32'hFFFF_FFFF, 32'h0000_00FF, 32'h0, 32'h0);

    // Requester 1 writes the value already present: no change.
    push(2'b10, 1'b0, 32'h0000_00FF);
    issue(2'b10, 32'h0, 32'h0, 32'h0000_00FF, 32'h0000_000F);

    // All-zero mask on requester 0: full handshake, no change.
    push(2'b01, 1'b0, 32'h0000_00FF);
    issue(2'b01, 32'h1234_5678, 32'h0, 32'h0, 32'h0);

    // Clear everything via requester 0.
    push(2'b01, 1'b1, 32'h0);
    issue(2'b01, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0);

    // All-zero mask on requester 1 leaves it as last winner.
    push(2'b10, 1'b0, 32'h0);
    issue(2'b10, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0);

    // Both requesting continuously: grants alternate every 3 cycles.
    push(2'b01, 1'b1, 32'hA);
    push(2'b10, 1'b1, 32'h5);
    push(2'b01, 1'b1, 32'hA);
    push(2'b10, 1'b1, 32'h5);
    wdata0 = 32'hA; wmask0 = 32'hF; wdata1 = 32'h5; wmask1 = 32'hF;
    req = 2'b11;
    repeat (12) @(posedge clk);
    #1 req = 2'b00;
    @(posedge clk); #1;

    // Lone requester 1 wins even though it was the last winner.
    push(2'b10, 1'b1, 32'h0000_0305);
    issue(2'b10, 32'h0, 32'h0, 32'h0000_0300, 32'h0000_0F00);

    // Reset pulsed during GRANT abandons the write.
    wdata0 = 32'h1234; wmask0 = 32'hFFFF_FFFF;
    req = 2'b01;
    @(posedge clk); #1;
    check("abort_gnt", W'(gnt), W'(2'b01));
    check("abort_state", W'(state), W'(GRANT));
    rst_n = 1'b0;
    #1;
    check("abort_gpio", gpio, 32'h0);
    check("abort_gnt_clr", W'(gnt), W'(0));
    check("abort_busy", W'(busy), W'(0));
    req = 2'b00;
    #5 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("post_abort_gpio", gpio, 32'h0);
    check("post_abort_changed", W'(changed), W'(0));
    check("post_abort_state", W'(state), W'(IDLE));

    // Pointer is back at requester 1, so requester 0 wins the contended pick.
    push(2'b01, 1'b1, 32'h0000_0011);
    issue(2'b11, 32'h0000_0011, 32'h0000_00FF, 32'h0000_0022, 32'h0000_00FF);

    repeat (4) @(posedge clk);
    #1;
    check("queue_empty", W'(exp_q.size()), W'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
